// File: rtl/exec_alu_pipe.sv
// Single-issue integer execute stage: 1-cycle ALU/shift/branch ops plus an iterative shift-add multiplier.
// Outputs are registered; MUL holds off new input until its result is presented.
module exec_alu_pipe #(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [3:0]           in_cond,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_rip,
    input  logic [4:0]           in_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [4:0]           out_flags,
    output logic                 out_branch,
    output logic [WIDTH-1:0]     out_target,
    output logic                 out_illegal
);

    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int SH_W  = $clog2(WIDTH);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_CMP  = 4'd5;
    localparam logic [3:0] OP_TEST = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SAR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_JCC  = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   out_result_q, out_result_d;
    logic [4:0]           out_flags_q, out_flags_d;
    logic                 out_branch_q, out_branch_d;
    logic [WIDTH-1:0]     out_target_q, out_target_d;
    logic                 out_illegal_q, out_illegal_d;

    // Single-cycle datapath
    logic [WIDTH:0]       sum, diff, shl_ext, shr_ext, sar_ext;
    logic [SH_W-1:0]      shamt;
    logic [WIDTH-1:0]     res, ret, tgt;
    logic                 cf, of, upd, br, ill, cond_base;
    logic [4:0]           alu_flags;

    always_comb begin
        sum       = {1'b0, in_a} + {1'b0, in_b};
        diff      = {1'b0, in_a} - {1'b0, in_b};
        shamt     = in_b[SH_W-1:0];
        shl_ext   = {1'b0, in_a} << shamt;
        shr_ext   = {in_a, 1'b0} >> shamt;
        sar_ext   = $signed({in_a, 1'b0}) >>> shamt;
        tgt       = in_rip + in_b;
        res       = '0;
        cf        = 1'b0;
        of        = 1'b0;
        upd       = 1'b1;
        br        = 1'b0;
        ill       = 1'b0;
        cond_base = 1'b0;
        case (in_cond[3:1])
            3'd0: cond_base = in_flags[4];
            3'd1: cond_base = in_flags[0];
            3'd2: cond_base = in_flags[2];
            3'd3: cond_base = in_flags[0] | in_flags[2];
            3'd4: cond_base = in_flags[3];
            3'd5: cond_base = in_flags[1];
            3'd6: cond_base = in_flags[3] ^ in_flags[4];
            default: cond_base = in_flags[2] | (in_flags[3] ^ in_flags[4]);
        endcase
        case (in_op)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                of  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res = diff[WIDTH-1:0];
                cf  = diff[WIDTH];
                of  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND, OP_TEST: res = in_a & in_b;
            OP_OR:           res = in_a | in_b;
            OP_XOR:          res = in_a ^ in_b;
            OP_MOV: begin
                res = in_b;
                upd = 1'b0;
            end
            OP_SHL, OP_SHR, OP_SAR: begin
                if (shamt == '0) begin
                    res = in_a;
                    upd = 1'b0;
                end else if (in_op == OP_SHL) begin
                    res = shl_ext[WIDTH-1:0];
                    cf  = shl_ext[WIDTH];
                    of  = (shamt == SH_W'(1)) && (shl_ext[WIDTH-1] ^ shl_ext[WIDTH]);
                end else if (in_op == OP_SHR) begin
                    res = shr_ext[WIDTH:1];
                    cf  = shr_ext[0];
                    of  = (shamt == SH_W'(1)) && in_a[WIDTH-1];
                end else begin
                    res = sar_ext[WIDTH:1];
                    cf  = sar_ext[0];
                end
            end
            OP_JCC: begin
                upd = 1'b0;
                br  = cond_base ^ in_cond[0];
            end
            OP_JMP: begin
                upd = 1'b0;
                br  = 1'b1;
            end
            default: begin
                upd = 1'b0;
                ill = 1'b1;
            end
        endcase
        alu_flags = upd ? {of, res[WIDTH-1], res == '0, ~^res[7:0], cf} : in_flags;
        ret       = (in_op == OP_CMP || in_op == OP_TEST) ? in_a : res;
    end

    // One multiplier digit per cycle, least-significant digit first
    logic [2*WIDTH-1:0] digit, acc_next;
    logic               mul_hi;
    logic [4:0]         mul_flags;

    always_comb begin
        digit     = {{(2*WIDTH-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
        acc_next  = acc_q + mcand_q * digit;
        mul_hi    = |acc_next[2*WIDTH-1:WIDTH];
        mul_flags = {mul_hi, acc_next[WIDTH-1], acc_next[WIDTH-1:0] == '0,
                     ~^acc_next[7:0], mul_hi};
    end

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_flags_d   = out_flags_q;
        out_branch_d  = out_branch_q;
        out_target_d  = out_target_q;
        out_illegal_d = out_illegal_q;
        if (out_valid_q && out_ready) begin
            out_valid_d   = 1'b0;
            out_branch_d  = 1'b0;
            out_target_d  = '0;
            out_illegal_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_op == OP_MUL) begin
                        state_d  = MUL_BUSY;
                        cnt_d    = CNT_W'(STEPS);
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, in_a};
                        mplier_d = in_b;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_result_d  = {{WIDTH{1'b0}}, ret};
                        out_flags_d   = alu_flags;
                        out_branch_d  = br;
                        out_target_d  = br ? tgt : '0;
                        out_illegal_d = ill;
                    end
                end
            end
            default: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << MUL_BITS;
                mplier_d = mplier_q >> MUL_BITS;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d       = IDLE;
                    out_valid_d   = 1'b1;
                    out_result_d  = acc_next;
                    out_flags_d   = mul_flags;
                    out_branch_d  = 1'b0;
                    out_target_d  = '0;
                    out_illegal_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_flags_q   <= '0;
            out_branch_q  <= 1'b0;
            out_target_q  <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_flags_q   <= out_flags_d;
            out_branch_q  <= out_branch_d;
            out_target_q  <= out_target_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_flags   = out_flags_q;
    assign out_branch  = out_branch_q;
    assign out_target  = out_target_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_exec_alu_pipe.sv
// Bench for exec_alu_pipe: directed vectors with literal expectations plus a scoreboard fed by a behavioural model.
module tb_exec_alu_pipe;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = '0;
    logic [3:0]   in_cond = '0;
    logic [63:0]  in_a = '0, in_b = '0, in_rip = '0;
    logic [4:0]   in_flags = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_result;
    logic [4:0]   out_flags;
    logic         out_branch;
    logic [63:0]  out_target;
    logic         out_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_xfer   = 0;
    int n_stall  = 0;
    int rst_seen = 0;
    bit ready_mode = 1'b0;

    exec_alu_pipe #(.WIDTH(64), .MUL_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_cond(in_cond), .in_a(in_a), .in_b(in_b), .in_rip(in_rip),
        .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_branch(out_branch),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset_n) rst_seen <= rst_seen + 1;
    always @(posedge clk) begin
        #1;
        out_ready = ready_mode ? ~out_ready : 1'b1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] res;
        logic [4:0]   flags;
        logic         br;
        logic [63:0]  tgt;
        logic         ill;
        logic         is_jump;
        int           lat;       // edges from accept edge to the edge that presents the result
        int           acc_edge;
    } exp_t;

    function automatic logic even_parity(input logic [7:0] v);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(v[i]);
        return (ones % 2) == 0;
    endfunction

    function automatic logic [65:0] sx(input logic [63:0] v);
        return {{2{v[63]}}, v};
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] cond, input logic [63:0] a,
                                   input logic [63:0] b, input logic [63:0] rip, input logic [4:0] fl);
        exp_t e;
        logic [127:0] wide;
        logic [65:0]  ts;
        logic [63:0]  r, t;
        logic of, cf, setf, take;
        logic fo, fs, fz, fp, fc;
        int n;
        {fo, fs, fz, fp, fc} = fl;
        e.res = '0; e.flags = fl; e.br = 1'b0; e.tgt = '0; e.ill = 1'b0;
        e.is_jump = 1'b0; e.lat = 0; e.acc_edge = 0;
        r = '0; of = 1'b0; cf = 1'b0; setf = 1'b0; take = 1'b0;
        case (op)
            4'd0: begin
                wide = 128'(a) + 128'(b); r = wide[63:0]; cf = wide[64];
                ts = sx(a) + sx(b); of = (ts != sx(r)); setf = 1'b1; e.res = 128'(r);
            end
            4'd1, 4'd5: begin
                r = a - b; cf = (a < b);
                ts = sx(a) - sx(b); of = (ts != sx(r)); setf = 1'b1;
                e.res = (op == 4'd5) ? 128'(a) : 128'(r);
            end
            4'd2, 4'd6: begin
                r = a & b; setf = 1'b1;
                e.res = (op == 4'd6) ? 128'(a) : 128'(r);
            end
            4'd3: begin r = a | b; setf = 1'b1; e.res = 128'(r); end
            4'd4: begin r = a ^ b; setf = 1'b1; e.res = 128'(r); end
            4'd7: e.res = 128'(b);
            4'd8, 4'd9, 4'd10: begin
                n = int'(b[5:0]);
                t = a;
                for (int k = 0; k < n; k++) begin
                    if (op == 4'd8) begin cf = t[63]; t = t << 1; end
                    else if (op == 4'd9) begin cf = t[0]; t = t >> 1; end
                    else begin cf = t[0]; t = {t[63], t[63:1]}; end
                end
                r = t; e.res = 128'(t);
                if (n != 0) begin
                    setf = 1'b1;
                    if (n == 1) of = (op == 4'd8) ? (r[63] ^ cf) : (op == 4'd9) ? a[63] : 1'b0;
                end
            end
            4'd11: begin
                wide = 128'(a) * 128'(b); e.res = wide; r = wide[63:0];
                cf = (wide[127:64] != 0); of = cf; setf = 1'b1; e.lat = 16;
            end
            4'd12, 4'd13: begin
                case (cond)
                    4'h0: take = fo;          4'h1: take = !fo;
                    4'h2: take = fc;          4'h3: take = !fc;
                    4'h4: take = fz;          4'h5: take = !fz;
                    4'h6: take = fc || fz;    4'h7: take = !(fc || fz);
                    4'h8: take = fs;          4'h9: take = !fs;
                    4'hA: take = fp;          4'hB: take = !fp;
                    4'hC: take = fs != fo;    4'hD: take = fs == fo;
                    4'hE: take = fz || (fs != fo);
                    default: take = !fz && (fs == fo);
                endcase
                e.is_jump = 1'b1;
                e.br = (op == 4'd13) ? 1'b1 : take;
                if (e.br) e.tgt = rip + b;
            end
            default: e.ill = 1'b1;
        endcase
        if (setf) e.flags = {of, r[63], r == 0, even_parity(r[7:0]), cf};
        return e;
    endfunction

    // Scoreboard: expectations pushed on accept, checked on every output transfer
    exp_t         sb[$];
    bit           fresh = 1'b1;
    bit           prev_stall = 1'b0;
    int           rst_handled = 0;
    logic [127:0] snap_res;
    logic [71:0]  snap_rest;

    always @(negedge clk) begin
        exp_t e;
        if (rst_seen != rst_handled) begin
            sb.delete();
            fresh = 1'b1;
            prev_stall = 1'b0;
            rst_handled = rst_seen;
        end
        if (reset_n) begin
            if (prev_stall) begin
                chk("stall_result", out_result, snap_res);
                chk("stall_ctrl", 128'({out_valid, out_flags, out_branch, out_target, out_illegal}), 128'(snap_rest));
            end
            if (!out_valid)
                chk("idle_zero", 128'({out_branch, out_illegal, out_target}), 128'(0));
            if (out_valid && fresh && sb.size() > 0)
                chk("sb_latency", 128'(cyc - sb[0].acc_edge), 128'(sb[0].lat));
            if (out_valid && out_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_out", 128'(out_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    if (!e.is_jump) chk("sb_result", out_result, e.res);
                    chk("sb_flags", 128'(out_flags), 128'(e.flags));
                    chk("sb_branch", 128'(out_branch), 128'(e.br));
                    chk("sb_illegal", 128'(out_illegal), 128'(e.ill));
                    if (e.br) chk("sb_target", 128'(out_target), 128'(e.tgt));
                end
            end
            if (out_valid && !out_ready) n_stall++;
            fresh      = !out_valid || out_ready;
            prev_stall = out_valid && !out_ready;
            snap_res   = out_result;
            snap_rest  = {out_valid, out_flags, out_branch, out_target, out_illegal};
            if (in_valid && in_ready) begin
                n_acc++;
                e = model(in_op, in_cond, in_a, in_b, in_rip, in_flags);
                e.acc_edge = cyc + 1;
                sb.push_back(e);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] cond = 4'd0, input logic [4:0] fl = 5'd0,
                        input logic [63:0] rip = 64'd0);
        bit acc;
        int n = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cond = cond; in_flags = fl; in_rip = rip;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Waits for out_valid at falling edges; lat = edges after the accept edge
    task automatic wait_out(input bit busy_chk, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
            if (busy_chk) chk("mul_in_ready_low", 128'(in_ready), 128'(0));
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL wait_out_timeout: out_valid never rose, required 1");
        end
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, vcount;
        exp_t m;
        logic [3:0] rop;

        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int lat, vcount;
        exp_t m;
        logic [3:0] rop;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_branch", 128'(out_branch), 128'(0));
        chk("rst_out_illegal", 128'(out_illegal), 128'(0));
        chk("rst_out_result", out_result, 128'(0));
        chk("rst_out_target", 128'(out_target), 128'(0));
        chk("rst_out_flags", 128'(out_flags), 128'(0));
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Pin the model against hand-computed values
        m = model(4'd0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd0);
        chk("model_add_flags", 128'(m.flags), 128'(5'b00111));
        m = model(4'd8, 4'd0, 64'h8000_0000_0000_0001, 64'd1, 64'd0, 5'd0);
        chk("model_shl_res", m.res, 128'd2);
        chk("model_shl_flags", 128'(m.flags), 128'(5'b10001));

        // ADD wrap to zero
        send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_out(1'b0, lat);
        chk("add_latency", 128'(lat), 128'(0));
        chk("add_result", out_result, 128'd0);
        chk("add_flags", 128'(out_flags), 128'(5'b00111));
        realign();

        // SUB signed overflow
        send(4'd1, 64'h8000_0000_0000_0000, 64'd1);
        wait_out(1'b0, lat);
        chk("sub_result", out_result, 128'(64'h7FFF_FFFF_FFFF_FFFF));
        chk("sub_flags", 128'(out_flags), 128'(5'b10010));
        realign();

        // MUL 2^63 * 4 = 2^65
        send(4'd11, 64'h8000_0000_0000_0000, 64'd4);
        wait_out(1'b1, lat);
        chk("mul_latency", 128'(lat), 128'(16));
        chk("mul_result", out_result, {62'd0, 2'b10, 64'd0});
        chk("mul_flags", 128'(out_flags), 128'(5'b10111));
        realign();

        // JCC Z taken / not taken
        send(4'd12, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd4, 5'b00100, 64'h1000);
        wait_out(1'b0, lat);
        chk("jcc_z_branch", 128'(out_branch), 128'(1));
        chk("jcc_z_target", 128'(out_target), 128'(64'hFF0));
        chk("jcc_z_flags", 128'(out_flags), 128'(5'b00100));
        realign();
        send(4'd12, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd4, 5'b00000, 64'h1000);
        wait_out(1'b0, lat);
        chk("jcc_nz_branch", 128'(out_branch), 128'(0));
        realign();

        // SHL by 1 and by 64 (masked to 0)
        send(4'd8, 64'h8000_0000_0000_0001, 64'd1);
        wait_out(1'b0, lat);
        chk("shl1_result", out_result, 128'd2);
        chk("shl1_flags", 128'(out_flags), 128'(5'b10001));
        realign();
        send(4'd8, 64'h8000_0000_0000_0001, 64'd64, 4'd0, 5'b01010);
        wait_out(1'b0, lat);
        chk("shl64_result", out_result, 128'(64'h8000_0000_0000_0001));
        chk("shl64_flags", 128'(out_flags), 128'(5'b01010));
        realign();

        // Illegal op and MOV
        send(4'd14, 64'h1234, 64'h5678, 4'd0, 5'b10101);
        wait_out(1'b0, lat);
        chk("ill_flag", 128'(out_illegal), 128'(1));
        chk("ill_result", out_result, 128'd0);
        chk("ill_flags", 128'(out_flags), 128'(5'b10101));
        realign();
        send(4'd7, 64'h1111, 64'hDEAD_BEEF, 4'd0, 5'b11000);
        wait_out(1'b0, lat);
        chk("mov_result", out_result, 128'(64'hDEAD_BEEF));
        chk("mov_flags", 128'(out_flags), 128'(5'b11000));
        realign();

        // Back-to-back ADD stream against a toggling consumer
        ready_mode = 1'b1;
        n_stall = 0;
        for (int i = 0; i < 8; i++) send(4'd0, 64'(i * 1000 + 7), 64'(i));
        repeat (20) @(posedge clk);
        ready_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stream_drained", 128'(sb.size()), 128'(0));
        chk("stream_count", 128'(n_xfer), 128'(n_acc));
        chk("stream_saw_stall", 128'(n_stall > 0), 128'(1));

        // Mixed random ops, scoreboard-checked
        ready_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop inside {4'd8, 4'd9, 4'd10})
                send(rop, {$urandom, $urandom}, 64'($urandom_range(0, 70)), 4'd0, 5'($urandom));
            else
                send(rop, (i % 3 == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom},
                     {$urandom, $urandom}, 4'($urandom), 5'($urandom), {$urandom, $urandom});
        end
        repeat (40) @(posedge clk);
        ready_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("random_drained", 128'(sb.size()), 128'(0));
        chk("random_count", 128'(n_xfer), 128'(n_acc));

        // Reset pulse in the middle of a multiply
        send(4'd11, 64'd3, 64'd5);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        chk("midmul_rst_valid", 128'(out_valid), 128'(0));
        reset_n = 1'b1;
        #1;
        chk("midmul_rst_in_ready", 128'(in_ready), 128'(1));
        vcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            vcount += int'(out_valid);
        end
        chk("midmul_no_result", 128'(vcount), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_alu_pipe.md
EXEC_ALU_PIPE -- requirements
Module: exec_alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the operand, rip and target width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter MUL_BITS, default 4, meaning the multiplier bits retired per cycle; WIDTH SHALL be divisible by MUL_BITS.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an operation this cycle.
REQ-007 The block SHALL have port in_op, input, 4 bits, with encoding 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 TEST, 7 MOV, 8 SHL, 9 SHR, 10 SAR, 11 MUL, 12 JCC, 13 JMP; 14 and 15 are illegal.
REQ-008 The block SHALL have port in_cond, input, 4 bits, the x86 Jcc condition code 0x0-0xF (O through NLE).
REQ-009 The block SHALL have ports in_a and in_b, input, WIDTH bits each, the operands; for JCC and JMP, in_b is the displacement.
REQ-010 The block SHALL have port in_rip, input, WIDTH bits, the next-instruction rip.
REQ-011 The block SHALL have port in_flags, input, 5 bits, the current flags {OF,SF,ZF,PF,CF}.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result; it replaces the old mem_blocked stall.
REQ-014 The block SHALL have port out_result, output, 2*WIDTH bits, the result; upper half is zero except for MUL.
REQ-015 The block SHALL have port out_flags, output, 5 bits, the updated {OF,SF,ZF,PF,CF}.
REQ-016 The block SHALL have port out_branch, output, 1 bit, meaning redirect fetch.
REQ-017 The block SHALL have port out_target, output, WIDTH bits, the redirect rip.
REQ-018 The block SHALL have port out_illegal, output, 1 bit, meaning an illegal in_op was consumed.

Function
REQ-019 Handshake: a transfer on either side SHALL occur when valid && ready are high at a rising edge; all outputs SHALL be registered.
REQ-020 FSM states SHALL be IDLE and MUL_BUSY; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-021 Non-MUL ops SHALL be accepted at edge N and give out_valid=1 with results after edge N, i.e. latency 1.
REQ-022 MUL accept SHALL go IDLE to MUL_BUSY, load a counter with WIDTH/MUL_BITS, and shift-add MUL_BITS bits per cycle.
REQ-023 MUL SHALL return to IDLE and assert out_valid after exactly WIDTH/MUL_BITS cycles from accept (16 for the defaults); in_ready is 0 throughout MUL_BUSY.
REQ-024 out_valid and all out_* SHALL hold stable while out_valid && !out_ready; out_valid SHALL clear after the transfer unless a new op is accepted on the same edge (back-to-back, full throughput).
REQ-025 ADD/SUB/CMP SHALL compute a WIDTH+1-bit result: CF=carry/borrow, OF per signed overflow, SF=msb, ZF=(result==0), PF=even parity of bits[7:0].
REQ-026 CMP and TEST SHALL set flags like SUB/AND but return out_result=in_a.
REQ-027 AND/OR/XOR/TEST SHALL set CF=OF=0, with SF/ZF/PF from the result.
REQ-028 MOV SHALL return in_b with flags unchanged.
REQ-029 Shift count = in_b masked to log2(WIDTH) bits; count 0 SHALL leave result=in_a and flags unchanged.
REQ-030 Nonzero shifts SHALL set CF=last bit shifted out; OF = msb(result)^CF for SHL, msb(in_a) for SHR, 0 for SAR, each for count 1 only, else 0.
REQ-031 MUL SHALL be an unsigned 2*WIDTH product; CF=OF=|upper half; SF/ZF/PF from the lower half.
REQ-032 JCC SHALL evaluate in_cond on in_flags; it asserts out_branch=1 with out_target=in_rip+in_b (modulo 2^WIDTH) if true, else out_branch=0; flags are unchanged.
REQ-033 JMP SHALL always assert out_branch with out_target=in_rip+in_b.
REQ-034 Illegal op SHALL be consumed at latency 1, with out_illegal=1, out_result=0 and flags unchanged.
REQ-035 out_branch, out_illegal and out_target SHALL be meaningful only while out_valid=1; otherwise 0.

Reset
REQ-036 reset_n low SHALL immediately set state=IDLE and out_valid, out_branch and out_illegal to 0; out_result, out_target, out_flags and the counter SHALL be 0.
REQ-037 Reset during MUL_BUSY SHALL abort the multiply, with no result emitted.
REQ-038 After reset_n rises, in_ready SHALL be 1 in the first cycle.

Verification
REQ-039 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 0, CF=1, ZF=1, PF=1, OF=0, SF=0, 1 cycle.
REQ-040 SUB a=0x8000_0000_0000_0000, b=1 -> result 0x7FFF_FFFF_FFFF_FFFF, OF=1, CF=0, SF=0.
REQ-041 MUL a=2^63, b=4 -> out_result = 2^65, CF=OF=1; out_valid exactly 16 cycles after accept; in_ready=0 meanwhile.
REQ-042 Back-to-back ADD stream with out_ready toggled 1,0,1 -> no loss or duplication; outputs stable while stalled.
REQ-043 JCC cond=4 (Z) with in_flags ZF=1, rip=0x1000, b=0xFFFF_FFFF_FFFF_FFF0 -> out_branch=1, target=0xFF0; ZF=0 -> out_branch=0.
REQ-044 SHL a=0x8000_0000_0000_0001, count 1 -> result 2, CF=1, OF=1; count 64 (masked to 0) -> result=a, flags unchanged; reset_n pulse mid-MUL -> out_valid stays 0.
